// File: rtl/hazard_ctrl_unit.sv
// Hazard controller on the read side of ID/EXE: PC/IF-ID hold, IF-ID flush, ID/EXE bubble.
// Optional ID-stage forwarding selects when FORWARD_PATH_EN is defined.
module hazard_ctrl_unit #(
    parameter int ASIZE        = 5,
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] id_rs1,
    input  logic             id_rs1_used,
    input  logic [ASIZE-1:0] id_rs2,
    input  logic             id_rs2_used,
    input  logic [ASIZE-1:0] ex_waddr,
    input  logic             ex_write_en,
    input  logic             ex_mem_read,
    input  logic [ASIZE-1:0] mem_waddr,
    input  logic             mem_write_en,
    input  logic             ex_branch_taken,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idexe_flush,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] LS_CNT     = 3'(LOAD_STALL);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;

    function automatic logic hit(input logic used, input logic [ASIZE-1:0] src,
                                 input logic we, input logic [ASIZE-1:0] waddr);
        return used && (src != '0) && we && (src == waddr);
    endfunction

    logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
    logic [2:0] need_a, need_b, need;

    assign ex_hit_a  = hit(id_rs1_used, id_rs1, ex_write_en,  ex_waddr);
    assign ex_hit_b  = hit(id_rs2_used, id_rs2, ex_write_en,  ex_waddr);
    assign mem_hit_a = hit(id_rs1_used, id_rs1, mem_write_en, mem_waddr);
    assign mem_hit_b = hit(id_rs2_used, id_rs2, mem_write_en, mem_waddr);

`ifdef FORWARD_PATH_EN
    // Only a load still in EXE cannot be forwarded.
    assign need_a = (ex_hit_a && ex_mem_read) ? LS_CNT : 3'd0;
    assign need_b = (ex_hit_b && ex_mem_read) ? LS_CNT : 3'd0;

    always_comb begin
        fwd_sel_a = 2'b00;
        fwd_sel_b = 2'b00;
        if (rst && state != STALL) begin
            if (ex_hit_a)       fwd_sel_a = ex_mem_read ? 2'b00 : 2'b01;
            else if (mem_hit_a) fwd_sel_a = 2'b10;
            if (ex_hit_b)       fwd_sel_b = ex_mem_read ? 2'b00 : 2'b01;
            else if (mem_hit_b) fwd_sel_b = 2'b10;
        end
    end
`else
    assign need_a = ex_hit_a ? 3'd2 : (mem_hit_a ? 3'd1 : 3'd0);
    assign need_b = ex_hit_b ? 3'd2 : (mem_hit_b ? 3'd1 : 3'd0);
    assign fwd_sel_a = 2'b00;
    assign fwd_sel_b = 2'b00;

    // Inputs consumed only by the forwarding build.
    logic unused_fwd;
    assign unused_fwd = ^{ex_mem_read, LS_CNT};
`endif

    assign need = (need_a > need_b) ? need_a : need_b;

    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;
        state_nxt   = state;
        cnt_nxt     = cnt;
        if (!rst) begin
            state_nxt = RUN;
            cnt_nxt   = 3'd0;
        end else if (ex_branch_taken) begin
            // A taken branch wins in every state, aborting a stall or restarting a flush.
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = FLUSH_LOAD;
            end else begin
                state_nxt = RUN;
                cnt_nxt   = 3'd0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (need != 3'd0) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idexe_flush = 1'b1;
                        if (need > 3'd1) begin
                            state_nxt = STALL;
                            cnt_nxt   = need - 3'd1;
                        end
                    end
                end
                STALL: begin
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idexe_flush = 1'b1;
                    cnt_nxt     = cnt - 3'd1;
                    if (cnt <= 3'd1) state_nxt = RUN;
                end
                FLUSH: begin
                    ifid_flush = 1'b1;
                    cnt_nxt    = cnt - 3'd1;
                    if (cnt <= 3'd1) state_nxt = RUN;
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule
